// File: rtl/axi_aw_w_arbiter.sv
// Shares one slave-side AXI write port between NUM_MASTERS masters: round-robin AW
// arbitration, with W bursts forwarded strictly in AW-grant order via a small order FIFO.
module axi_aw_w_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int AW_W        = 64,
  parameter int W_W         = 37,
  parameter int ORDER_DEPTH = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_MASTERS-1:0]           m_awvalid,
  input  logic [NUM_MASTERS*AW_W-1:0]      m_awpayload,
  output logic [NUM_MASTERS-1:0]           m_awready,
  output logic                             s_awvalid,
  output logic [AW_W-1:0]                  s_awpayload,
  input  logic                             s_awready,
  input  logic [NUM_MASTERS-1:0]           m_wvalid,
  input  logic [NUM_MASTERS-1:0]           m_wlast,
  input  logic [NUM_MASTERS*W_W-1:0]       m_wpayload,
  output logic [NUM_MASTERS-1:0]           m_wready,
  output logic                             s_wvalid,
  output logic                             s_wlast,
  output logic [W_W-1:0]                   s_wpayload,
  input  logic                             s_wready,
  output logic [$clog2(NUM_MASTERS)-1:0]   aw_grant_idx,
  output logic [ORDER_DEPTH:0]             order_count
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int DEPTH = 1 << ORDER_DEPTH;
  localparam logic [ORDER_DEPTH:0] FULL_COUNT = DEPTH[ORDER_DEPTH:0];
  localparam logic [IDX_W-1:0]     LAST_IDX   = IDX_W'(NUM_MASTERS - 1);

  typedef enum logic {IDLE, HOLD} aw_state_t;

  aw_state_t              state, state_next;
  logic [IDX_W-1:0]       grant, grant_next, last_grant, pick;
  logic                   pick_valid;
  logic                   push, pop;
  logic [IDX_W-1:0]       order_mem [DEPTH];
  logic [ORDER_DEPTH-1:0] head, tail;
  logic [ORDER_DEPTH:0]   count;
  logic [IDX_W-1:0]       head_idx;
  logic [AW_W-1:0]        aw_arr [NUM_MASTERS];
  logic [W_W-1:0]         w_arr  [NUM_MASTERS];

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
    assign aw_arr[g] = m_awpayload[g*AW_W +: AW_W];
    assign w_arr[g]  = m_wpayload[g*W_W +: W_W];
  end

  function automatic logic [IDX_W-1:0] wrap_idx(input int v);
    return IDX_W'(v % NUM_MASTERS);
  endfunction

  // Scan downward so the closest requester after last_grant is the final winner.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      if (m_awvalid[wrap_idx(int'(last_grant) + k)]) begin
        pick       = wrap_idx(int'(last_grant) + k);
        pick_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    grant_next = grant;
    push       = 1'b0;
    s_awvalid  = 1'b0;
    m_awready  = '0;
    case (state)
      IDLE: begin
        if (pick_valid && count != FULL_COUNT) begin
          grant_next = pick;
          state_next = HOLD;
        end
      end
      HOLD: begin
        s_awvalid        = 1'b1;
        m_awready[grant] = s_awready;
        if (s_awready) begin
          push       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign s_awpayload  = aw_arr[grant];
  assign aw_grant_idx = grant;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= LAST_IDX;
    end else begin
      state <= state_next;
      grant <= grant_next;
      if (push) last_grant <= grant;
    end
  end

  // W channel follows the oldest granted master until its WLAST beat is accepted.
  assign head_idx = order_mem[head];

  always_comb begin
    s_wvalid   = 1'b0;
    s_wlast    = 1'b0;
    m_wready   = '0;
    s_wpayload = w_arr[head_idx];
    if (count != '0) begin
      s_wvalid           = m_wvalid[head_idx];
      s_wlast            = m_wlast[head_idx];
      m_wready[head_idx] = s_wready;
    end
  end

  assign pop         = s_wvalid & s_wready & s_wlast;
  assign order_count = count;

  always_ff @(posedge clk) begin
    if (push) order_mem[tail] <= grant;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_aw_w_arbiter.sv
// Self-checking bench for axi_aw_w_arbiter: table of AW vectors, directed ordering/full/reset
// sequences, and randomized traffic against a queue-based reference model.
module tb_axi_aw_w_arbiter;

  localparam int N     = 4;
  localparam int AW_W  = 64;
  localparam int W_W   = 37;
  localparam int OD    = 3;
  localparam int DEPTH = 1 << OD;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    m_awvalid, m_awready, m_wvalid, m_wlast, m_wready;
  logic [N*AW_W-1:0] m_awpayload;
  logic [N*W_W-1:0]  m_wpayload;
  logic            s_awvalid, s_awready, s_wvalid, s_wlast, s_wready;
  logic [AW_W-1:0] s_awpayload;
  logic [W_W-1:0]  s_wpayload;
  logic [1:0]      aw_grant_idx;
  logic [OD:0]     order_count;

  logic [AW_W-1:0] awp [N];
  logic [W_W-1:0]  wp  [N];

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign m_awpayload[g*AW_W +: AW_W] = awp[g];
    assign m_wpayload[g*W_W +: W_W]    = wp[g];
  end

  always #5 clk = ~clk;

  axi_aw_w_arbiter #(.NUM_MASTERS(N), .AW_W(AW_W), .W_W(W_W), .ORDER_DEPTH(OD)) dut (
    .clk(clk), .rst(rst),
    .m_awvalid(m_awvalid), .m_awpayload(m_awpayload), .m_awready(m_awready),
    .s_awvalid(s_awvalid), .s_awpayload(s_awpayload), .s_awready(s_awready),
    .m_wvalid(m_wvalid), .m_wlast(m_wlast), .m_wpayload(m_wpayload), .m_wready(m_wready),
    .s_wvalid(s_wvalid), .s_wlast(s_wlast), .s_wpayload(s_wpayload), .s_wready(s_wready),
    .aw_grant_idx(aw_grant_idx), .order_count(order_count)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: a pending AW grant plus a queue of granted master indices.
  bit mdl_hold;
  int mdl_grant, mdl_last, mdl_idx;
  int q[$];

  typedef struct {
    logic       rst;
    logic [3:0] awvalid;
    logic       awready;
    logic       exp_awvalid;
    logic [3:0] exp_awready;
    logic [1:0] exp_idx;
    logic [3:0] exp_count;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int next_pick();
    for (int k = 1; k <= N; k++) begin
      if (m_awvalid[(mdl_last + k) % N]) return (mdl_last + k) % N;
    end
    return -1;
  endfunction

  task automatic model_step();
    int sz, p;
    bit do_pop;
    if (!rst) begin
      mdl_hold = 0; mdl_grant = 0; mdl_last = N - 1; mdl_idx = 0;
      q.delete();
    end else begin
      sz     = q.size();
      do_pop = (sz != 0) && m_wvalid[q[0]] && s_wready && m_wlast[q[0]];
      p      = next_pick();
      if (mdl_hold) begin
        if (s_awready) begin
          q.push_back(mdl_grant);
          mdl_last = mdl_grant;
          mdl_hold = 0;
        end
      end else if (sz < DEPTH && p >= 0) begin
        mdl_hold = 1; mdl_grant = p; mdl_idx = p;
      end
      if (do_pop) void'(q.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] awv, input logic awr,
                               input logic [3:0] wv, input logic [3:0] wl, input logic wr);
    rst = r; m_awvalid = awv; s_awready = awr;
    m_wvalid = wv; m_wlast = wl; s_wready = wr;
    #1;
  endtask

  task automatic checkOutput();
    logic [3:0] e_awready, e_wready;
    int h;
    e_awready = '0;
    e_wready  = '0;
    if (mdl_hold) e_awready[mdl_grant] = s_awready;
    chk("s_awvalid", s_awvalid, mdl_hold);
    chk("m_awready", m_awready, e_awready);
    if (mdl_hold) chk("s_awpayload", s_awpayload, awp[mdl_grant]);
    chk("aw_grant_idx", aw_grant_idx, mdl_idx);
    chk("order_count", order_count, q.size());
    if (q.size() != 0) begin
      h = q[0];
      e_wready[h] = s_wready;
      chk("s_wvalid", s_wvalid, m_wvalid[h]);
      chk("s_wlast", s_wlast, m_wlast[h]);
      chk("s_wpayload", s_wpayload, wp[h]);
    end else begin
      chk("s_wvalid_empty", s_wvalid, 1'b0);
    end
    chk("m_wready", m_wready, e_wready);
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 4'b0, 1'b0, 4'b0, 4'b0, 1'b0);
    tick();
    tick();
    applyStimulus(1'b1, 4'b0, 1'b0, 4'b0, 4'b0, 1'b0);
  endtask

  initial begin
    logic [3:0] hs;

    vecs[0]  = '{1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 2'd0, 4'd0};
    vecs[1]  = '{1'b1, 4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0, 4'd0};
    vecs[2]  = '{1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 2'd0, 4'd1};
    vecs[3]  = '{1'b1, 4'b1111, 1'b1, 1'b1, 4'b0010, 2'd1, 4'd1};
    vecs[4]  = '{1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 2'd1, 4'd2};
    vecs[5]  = '{1'b1, 4'b1111, 1'b1, 1'b1, 4'b0100, 2'd2, 4'd2};
    vecs[6]  = '{1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 2'd2, 4'd3};
    vecs[7]  = '{1'b1, 4'b1111, 1'b1, 1'b1, 4'b1000, 2'd3, 4'd3};
    vecs[8]  = '{1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 2'd3, 4'd4};
    vecs[9]  = '{1'b1, 4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0, 4'd4};
    vecs[10] = '{1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 2'd0, 4'd5};
    vecs[11] = '{1'b0, 4'b1111, 1'b1, 1'b1, 4'b0010, 2'd1, 4'd5};
    vecs[12] = '{1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 2'd0, 4'd0};
    vecs[13] = '{1'b1, 4'b1111, 1'b0, 1'b1, 4'b0000, 2'd0, 4'd0};
    vecs[14] = '{1'b1, 4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0, 4'd0};

    for (int i = 0; i < N; i++) begin
      awp[i] = {32'hA0A0_0000 | 32'(i), $urandom};
      wp[i]  = {5'(i), $urandom};
    end
    mdl_hold = 0; mdl_grant = 0; mdl_last = N - 1; mdl_idx = 0;

    // Reset state and round-robin grant sequence from the vector table.
    doReset();
    chk("reset_awvalid", s_awvalid, 1'b0);
    chk("reset_count", order_count, 0);
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].awvalid, vecs[i].awready, 4'b0, 4'b0, 1'b0);
      chk($sformatf("vec%0d_awvalid", i), s_awvalid, vecs[i].exp_awvalid);
      chk($sformatf("vec%0d_awready", i), m_awready, vecs[i].exp_awready);
      chk($sformatf("vec%0d_idx", i), aw_grant_idx, vecs[i].exp_idx);
      chk($sformatf("vec%0d_count", i), order_count, vecs[i].exp_count);
      checkOutput();
      tick();
    end

    // Stalled AW: master 2 grant stays locked while master 0 waits.
    doReset();
    applyStimulus(1'b1, 4'b0100, 1'b0, 4'b0, 4'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 4'b0101, 1'b0, 4'b0, 4'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_awvalid", s_awvalid, 1'b1);
      chk("stall_idx", aw_grant_idx, 2);
      chk("stall_payload", s_awpayload, awp[2]);
      checkOutput();
      tick();
    end
    applyStimulus(1'b1, 4'b0101, 1'b1, 4'b0, 4'b0, 1'b0);
    chk("stall_release_ready", m_awready, 4'b0100);
    tick();
    applyStimulus(1'b1, 4'b0001, 1'b0, 4'b0, 4'b0, 1'b0);
    tick();
    chk("after_stall_idx", aw_grant_idx, 0);
    chk("after_stall_awvalid", s_awvalid, 1'b1);

    // Reset in the middle of a W burst and an AW HOLD.
    applyStimulus(1'b1, 4'b0001, 1'b0, 4'b0100, 4'b0000, 1'b1);
    checkOutput();
    tick();
    checkOutput();
    tick();
    applyStimulus(1'b0, 4'b0001, 1'b0, 4'b0100, 4'b0000, 1'b1);
    tick();
    applyStimulus(1'b1, 4'b0, 1'b0, 4'b0100, 4'b0000, 1'b1);
    chk("midrst_awvalid", s_awvalid, 1'b0);
    chk("midrst_wvalid", s_wvalid, 1'b0);
    chk("midrst_awready", m_awready, 4'b0);
    chk("midrst_wready", m_wready, 4'b0);
    chk("midrst_count", order_count, 0);
    applyStimulus(1'b1, 4'b1111, 1'b0, 4'b0, 4'b0, 1'b0);
    tick();
    chk("midrst_first_grant", aw_grant_idx, 0);
    checkOutput();

    // W ordering: AW order 1 then 3; master 3 waits for master 1's 4-beat burst.
    doReset();
    applyStimulus(1'b1, 4'b0010, 1'b1, 4'b0, 4'b0, 1'b0);
    tick();
    tick();
    applyStimulus(1'b1, 4'b1000, 1'b1, 4'b0, 4'b0, 1'b0);
    tick();
    tick();
    applyStimulus(1'b1, 4'b0, 1'b0, 4'b0, 4'b0, 1'b0);
    chk("order_count_2", order_count, 2);
    for (int b = 1; b <= 4; b++) begin
      wp[1] = {5'd1, 32'(b)};
      applyStimulus(1'b1, 4'b0, 1'b0, 4'b1010, {1'b1, 1'b0, (b == 4), 1'b0}, 1'b1);
      chk("burst_wready", m_wready, 4'b0010);
      chk("burst_wlast", s_wlast, (b == 4));
      chk("burst_payload", s_wpayload, {5'd1, 32'(b)});
      checkOutput();
      tick();
    end
    applyStimulus(1'b1, 4'b0, 1'b0, 4'b1000, 4'b1000, 1'b1);
    chk("order_count_1", order_count, 1);
    chk("second_wready", m_wready, 4'b1000);
    checkOutput();
    tick();
    chk("order_count_0", order_count, 0);

    // Fill the order FIFO, hit the full block, then push+pop across the pointer wrap.
    doReset();
    applyStimulus(1'b1, 4'b1111, 1'b1, 4'b0, 4'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      checkOutput();
      tick();
    end
    chk("full_count", order_count, DEPTH);
    for (int i = 0; i < 4; i++) begin
      chk("full_blocks_aw", s_awvalid, 1'b0);
      checkOutput();
      tick();
    end
    applyStimulus(1'b1, 4'b1111, 1'b1, 4'b0001, 4'b0001, 1'b1);
    chk("full_pop_ready", m_wready, 4'b0001);
    checkOutput();
    tick();
    applyStimulus(1'b1, 4'b1111, 1'b1, 4'b0, 4'b0, 1'b0);
    chk("after_pop_count", order_count, DEPTH - 1);
    chk("after_pop_idle", s_awvalid, 1'b0);
    checkOutput();
    tick();
    chk("resume_awvalid", s_awvalid, 1'b1);
    chk("resume_idx", aw_grant_idx, 0);
    applyStimulus(1'b1, 4'b0001, 1'b1, 4'b0010, 4'b0010, 1'b1);
    checkOutput();
    tick();
    applyStimulus(1'b1, 4'b0, 1'b0, 4'b1111, 4'b1111, 1'b1);
    chk("push_pop_count", order_count, DEPTH - 1);
    for (int i = 0; i < DEPTH - 1; i++) begin
      checkOutput();
      tick();
    end
    chk("drain_count", order_count, 0);

    // Randomized traffic; AW requesters hold valid until their handshake.
    doReset();
    hs = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (hs[i] || !m_awvalid[i]) begin
          m_awvalid[i] = ($urandom_range(0, 2) == 0);
          awp[i] = {$urandom, $urandom};
        end
        m_wvalid[i] = $urandom_range(0, 1);
        m_wlast[i]  = ($urandom_range(0, 2) == 0);
        wp[i]       = {5'($urandom), $urandom};
      end
      rst       = ($urandom_range(0, 299) != 0);
      s_awready = $urandom_range(0, 1);
      s_wready  = ($urandom_range(0, 3) != 0);
      #1;
      checkOutput();
      hs = m_awvalid & m_awready;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
